alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front-end for the 4-bit combinational ALU. Accepts 9-bit instructions over a valid/ready handshake into a small FIFO and owns a 4×4-bit register file. It issues one instruction at a time by driving registered operands and opcode into the ALU, then writes the ALU result back. It also exposes a write-back strobe and a debug read port.

## Interface
- DATA_W, 4, operand/result width; must match the ALU.
- NREG, 4, register-file entries; register index width is 2.
- FIFO_DEPTH, 4, instruction queue depth; power of two.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  9  [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2; for LDI, {rs1,rs2} is imm4.
- alu_a, alu_b  out  DATA_W  registered operands to the ALU.
- alu_op  out  3  registered ALU opcode; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR.
- alu_result  in  DATA_W  combinational ALU result.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  2  destination written.
- wb_data  out  DATA_W  value written.
- wb_err  out  1  retired instruction was illegal (op 111).
- dbg_sel  in  2  debug read index.
- dbg_data  out  DATA_W  combinational regfile[dbg_sel].
- busy  out  1  FSM not IDLE, or FIFO non-empty.

## Operation
- Push happens when in_valid && in_ready. A push while full is impossible, because in_ready is low. Push and pop in the same cycle are both performed, and the count is unchanged.
- The FSM has two states, IDLE and EXEC.
- IDLE, FIFO non-empty: pop the head and decode it.
  - ALU op (000–101): latch alu_a = reg[rs1], alu_b = reg[rs2], alu_op = op. Go to EXEC.
  - LDI (110): latch the pending value imm4. alu_* hold their previous values. Go to EXEC.
  - Illegal (111): alu_* hold. Go to EXEC with the error bit set.
- EXEC: always returns to IDLE on the next edge. At that edge:
  - ALU op: reg[rd] ← alu_result.
  - LDI: reg[rd] ← imm4.
  - Illegal: no regfile write; wb_data ← 0 and wb_err ← 1.
  - In all cases, wb_valid/wb_rd/wb_data are registered for one cycle.
- Operands are read from the regfile at pop time. The previous instruction's write completed before the next pop, so there are no data hazards and no forwarding.
- Arithmetic is the ALU's modulo-2^DATA_W wrap. Example: 0xF + 0x1 = 0x0; 0x0 − 0x1 = 0xF.
- Reset values: all registers 0, FIFO empty, state IDLE, alu_a/alu_b/alu_op 0, wb_valid/wb_rd/wb_data/wb_err 0. in_ready is 1 after reset is released.
- Reset mid-operation: the in-flight instruction and queued entries are dropped, and no wb_valid is emitted.

## Timing
- Push at edge E0 into an empty queue with FSM IDLE:
  - pop at E1; alu_* valid during E1–E2;
  - write-back at E2; wb_valid high for the cycle after E2.
  - Latency from accept to wb_valid is 3 cycles.
- Throughput is one instruction per 2 cycles. Back-to-back pops occur at E1, E3, E5, …
- wb_valid is never high for two consecutive cycles.
- in_ready deasserts the cycle after the FIFO_DEPTH-th unpopped push. It reasserts the cycle after the next pop.
- dbg_data reflects a write on the cycle after the write edge.

## Configuration
- ALU_ISSUE_FLAGS_EN defined:
  - adds output wb_zero (1 bit), registered with wb_valid, equal to (wb_data == 0);
  - the flag is 0 on illegal-instruction retire;
  - the reset value is 0.
- Undefined: the port is absent, with no other behavioural change.

## Structure
- Shared package alu_pkg contains:
  - the opcode localparams (OP_ADD…OP_XNOR, OP_LDI = 3'b110, OP_ILL = 3'b111);
  - the instruction field offsets;
  - the FSM state enum.
- Sub-module alu_issue_fifo: a synchronous FIFO with push/pop/full/empty, parameterised by width and depth.
- The regfile and FSM stay in the top level.

## Test plan
- Reset, then apply LDI r1,5; LDI r2,3; ADD r0,r1,r2 → wb sequence (1,5), (2,3), (0,8). dbg_sel = 0 reads 8.
- LDI r1,0; LDI r2,1; SUB r3,r1,r2 → wb_data = 0xF. With ALU_ISSUE_FLAGS_EN, an ADD of 0xF + 0x1 gives wb_data = 0 and wb_zero = 1.
- Hold in_valid for 6 instructions while the FSM is busy → in_ready drops after the 4th unpopped push. No instruction is lost or duplicated, and 6 wb pulses arrive spaced 2 cycles apart.
- Op 111 to rd = 2 after LDI r2,9 → wb_valid = 1, wb_err = 1, wb_data = 0, and reg2 is still 9.
- Dependent chain LDI r1,6; XOR r1,r1,r1; OR r2,r1,r1 → r1 = 0, r2 = 0, with correct operands with no stall beyond 2 cycles per instruction.
- Assert rst_n low during EXEC with 3 entries queued → no wb_valid; after release, busy = 0, in_ready = 1, and all dbg reads return 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, instruction field layout and FSM state type for the ALU issue front-end.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Instruction layout: [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2; LDI reuses [3:0] as imm4.
  localparam int INSTR_W = 9;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 2;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Show-ahead synchronous FIFO: rdata presents the head entry whenever empty is low.
module alu_issue_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: instruction FIFO, 4-entry regfile and IDLE/EXEC sequencer around an external ALU.
// Optional macro ALU_ISSUE_FLAGS_EN adds the registered wb_zero flag output.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int NREG       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [1:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic              wb_zero,
`endif
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy
);

  state_t              state;
  state_t              state_next;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [INSTR_W-1:0]  head;
  logic [2:0]          head_op;
  logic [1:0]          head_rd;
  logic [1:0]          head_rs1;
  logic [1:0]          head_rs2;
  logic [2:0]          pend_op;
  logic [1:0]          pend_rd;
  logic [IMM_W-1:0]    pend_imm;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   exec_data;
  logic                reg_we;

  alu_issue_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (in_instr),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_data  = regs[dbg_sel];

  assign head_op  = head[OP_LSB +: 3];
  assign head_rd  = head[RD_LSB +: 2];
  assign head_rs1 = head[RS1_LSB +: 2];
  assign head_rs2 = head[RS2_LSB +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Value retired in EXEC; illegal ops retire zero and skip the regfile.
  always_comb begin
    exec_data = alu_result;
    reg_we    = (state == ST_EXEC) && (pend_op != OP_ILL);
    case (pend_op)
      OP_LDI:  exec_data = DATA_W'(pend_imm);
      OP_ILL:  exec_data = '0;
      default: exec_data = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[pend_rd] <= exec_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      pend_op  <= '0;
      pend_rd  <= '0;
      pend_imm <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      wb_zero  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      if (fifo_pop) begin
        pend_op  <= head_op;
        pend_rd  <= head_rd;
        pend_imm <= head[IMM_LSB +: IMM_W];
        // Operands are read here; the previous write already landed, so no forwarding is needed.
        if (is_alu_op(head_op)) begin
          alu_a  <= regs[head_rs1];
          alu_b  <= regs[head_rs2];
          alu_op <= head_op;
        end
      end
      if (state == ST_EXEC) begin
        wb_valid <= 1'b1;
        wb_rd    <= pend_rd;
        wb_data  <= exec_data;
        wb_err   <= (pend_op == OP_ILL);
`ifdef ALU_ISSUE_FLAGS_EN
        wb_zero  <= (pend_op != OP_ILL) && (exec_data == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: in-order transaction model plus directed and random stimulus.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       wb_err;
`ifdef ALU_ISSUE_FLAGS_EN
  logic       wb_zero;
`endif
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;
  logic       busy;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_err     (wb_err),
`ifdef ALU_ISSUE_FLAGS_EN
    .wb_zero    (wb_zero),
`endif
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .busy       (busy)
  );

  // Combinational ALU that the controller drives.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = ~(alu_a ^ alu_b);
      default: alu_result = 4'h0;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wb_cyc = -100;
  logic [3:0] acc_regs [4];
  logic [3:0] ret_regs [4];
  logic [6:0] exp_q [$];
  int burst_cycs [$];
  bit burst_mode = 0;
  bit saw_not_ready = 0;
  logic [1:0] last_wb_rd;
  logic [3:0] last_wb_data;
  logic last_wb_err;
  logic last_wb_zero;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [8:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  // Sequential-semantics model: instructions retire in acceptance order with no hazards.
  task automatic model_accept(input logic [8:0] ins);
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] a, b, d;
    logic ill;
    op = ins[8:6];
    rd = ins[5:4];
    a  = acc_regs[ins[3:2]];
    b  = acc_regs[ins[1:0]];
    ill = (op == 3'd7);
    case (op)
      3'd0: d = a + b;
      3'd1: d = a - b;
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: d = ~(a ^ b);
      3'd6: d = ins[3:0];
      default: d = 4'h0;
    endcase
    if (!ill) acc_regs[rd] = d;
    exp_q.push_back({ill, rd, d});
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic offer(input logic [8:0] ins);
    int n;
    bit got;
    n = 0;
    got = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!got && n < 50) begin
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (got) model_accept(ins);
    end
    if (!got) check("offer_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      acc_regs[i] = 4'h0;
      ret_regs[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    logic [6:0] e;
    cyc++;
    if (!rst_n) begin
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      last_wb_cyc = -100;
    end else begin
      if (wb_valid) begin
        $display("wb cycle=%0d rd=%0d data=%0h err=%0d", cyc, wb_rd, wb_data, wb_err);
        check("wb_pending", 32'(exp_q.size() > 0), 32'd1);
        check("wb_gap", 32'((cyc - last_wb_cyc) >= 2), 32'd1);
        last_wb_cyc = cyc;
        if (burst_mode) burst_cycs.push_back(cyc);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wb_err", 32'(wb_err), 32'(e[6]));
          check("wb_rd", 32'(wb_rd), 32'(e[5:4]));
          check("wb_data", 32'(wb_data), 32'(e[3:0]));
`ifdef ALU_ISSUE_FLAGS_EN
          check("wb_zero", 32'(wb_zero), 32'(!e[6] && e[3:0] == 4'h0));
`endif
          if (!e[6]) ret_regs[e[5:4]] = e[3:0];
        end
        last_wb_rd   = wb_rd;
        last_wb_data = wb_data;
        last_wb_err  = wb_err;
`ifdef ALU_ISSUE_FLAGS_EN
        last_wb_zero = wb_zero;
`else
        last_wb_zero = 1'b0;
`endif
      end
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (!in_ready) begin
        saw_not_ready = 1;
        check("ready_full", 32'(exp_q.size() >= 4), 32'd1);
      end
      check("dbg", 32'(dbg_data), 32'(ret_regs[dbg_sel]));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0;
    in_instr = '0;
    dbg_sel  = 2'd0;
    rst_n    = 1'b1;
    #2;
    do_reset();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);

    // Latency: accept at E0, wb visible after E2
    offer(ldi(2'd1, 4'd5));
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_e0", 32'(wb_valid), 32'd0);
    @(negedge clk);
    check("lat_e1", 32'(wb_valid), 32'd0);
    @(negedge clk);
    check("lat_e2", 32'(wb_valid), 32'd1);
    check("lat_data", 32'(wb_data), 32'd5);
    @(posedge clk);
    #1;
    offer(ldi(2'd2, 4'd3));
    offer(mk(OP_ADD, 2'd0, 2'd1, 2'd2));
    drain();
    dbg_sel = 2'd0;
    #1;
    check("add_r0", 32'(dbg_data), 32'h8);
    check("add_wb_rd", 32'(last_wb_rd), 32'd0);

    // Wrap on subtraction
    offer(ldi(2'd1, 4'd0));
    offer(ldi(2'd2, 4'd1));
    offer(mk(OP_SUB, 2'd3, 2'd1, 2'd2));
    drain();
    dbg_sel = 2'd3;
    #1;
    check("sub_r3", 32'(dbg_data), 32'hF);

`ifdef ALU_ISSUE_FLAGS_EN
    offer(ldi(2'd1, 4'hF));
    offer(ldi(2'd2, 4'h1));
    offer(mk(OP_ADD, 2'd0, 2'd1, 2'd2));
    drain();
    check("zero_data", 32'(last_wb_data), 32'h0);
    check("zero_flag", 32'(last_wb_zero), 32'd1);
`endif

    // Illegal opcode
    offer(ldi(2'd2, 4'd9));
    offer(mk(OP_ILL, 2'd2, 2'd0, 2'd0));
    drain();
    dbg_sel = 2'd2;
    #1;
    check("ill_err", 32'(last_wb_err), 32'd1);
    check("ill_data", 32'(last_wb_data), 32'h0);
    check("ill_rd", 32'(last_wb_rd), 32'd2);
    check("ill_r2_kept", 32'(dbg_data), 32'h9);

    // Dependent chain
    offer(ldi(2'd1, 4'd6));
    offer(mk(OP_XOR, 2'd1, 2'd1, 2'd1));
    offer(mk(OP_OR, 2'd2, 2'd1, 2'd1));
    drain();
    dbg_sel = 2'd1;
    #1;
    check("chain_r1", 32'(dbg_data), 32'h0);
    dbg_sel = 2'd2;
    #1;
    check("chain_r2", 32'(dbg_data), 32'h0);

    // Back-to-back burst fills the FIFO
    burst_mode = 1;
    saw_not_ready = 0;
    burst_cycs.delete();
    for (int i = 0; i < 10; i++) begin
      offer(mk(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))));
    end
    drain();
    burst_mode = 0;
    check("burst_backpressure", 32'(saw_not_ready), 32'd1);
    check("burst_count", 32'(burst_cycs.size()), 32'd10);
    for (int i = 1; i < burst_cycs.size(); i++) begin
      check("burst_spacing", 32'(burst_cycs[i] - burst_cycs[i-1]), 32'd2);
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      dbg_sel = 2'($urandom_range(0, 3));
      offer(9'($urandom_range(0, 511)));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset during EXEC with 3 entries queued
    for (int i = 0; i < 6; i++) begin
      offer(ldi(2'(i), 4'($urandom_range(1, 15))));
    end
    in_valid = 1'b0;
    do_reset();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check("mid_rst_dbg", 32'(dbg_data), 32'h0);
    end
    repeat (6) @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
